// File: rtl/md5_step_engine.sv
// -----------------------------------------------------------------------------
// md5_step_engine
//
// Iterative MD5 compression core. One 512-bit message block is processed in
// 64 steps, one step per clock, followed by a single ADD cycle that folds the
// working registers back into the chaining value that came in with the block.
//
// The MD5 round function (F/G/H/I selected by a 2-bit select and fed with the
// current b/c/d working words) is modelled as a small combinational block
// inside this module; the step datapath drives its select and operands and
// consumes its f output.
//
// Ports
//   clk    in   1    single clock, all state updates on the rising edge
//   reset  in   1    synchronous, active-high reset
//   start  in   1    request to process one block, sampled only when idle
//   msg    in   512  message block, msg[32j+31:32j] = M[j], j = 0..15
//   h_in   in   128  chaining value: [31:0]=A [63:32]=B [95:64]=C [127:96]=D
//   busy   out  1    high from the accept edge through the ADD cycle
//   done   out  1    one-cycle pulse; h_out is valid from this cycle onward
//   h_out  out  128  updated chaining value, same packing as h_in
//
// Timing: start accepted at edge E0, steps 0..63 at edges E1..E64, done and
// h_out registered at E65. The engine is idle again in the done cycle, so a
// start held high there is accepted at the following edge.
// -----------------------------------------------------------------------------
module md5_step_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] msg,
  input  logic [127:0] h_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] h_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ADD  = 2'd2
  } state_e;

  // K[i] = floor(|sin(i+1)| * 2^32)
  localparam logic [31:0] K_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [5:0]     step_q,  step_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic [31:0]    c_q, c_d;
  logic [31:0]    d_q, d_d;
  logic [511:0]   msg_q,   msg_d;    // block latched at accept
  logic [127:0]   h0_q,    h0_d;     // chaining value latched at accept
  logic [127:0]   h_out_q, h_out_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;

  // ---------------------------------------------------------------------------
  // Round-function interface: select plus b/c/d operands in, f out
  // ---------------------------------------------------------------------------
  logic [1:0]     rf_sel;
  logic [31:0]    rf_b, rf_c, rf_d;
  logic [31:0]    rf_f;

  assign rf_sel = step_q[5:4];
  assign rf_b   = b_q;
  assign rf_c   = c_q;
  assign rf_d   = d_q;

  always_comb begin
    case (rf_sel)
      2'd0:    rf_f = (rf_b & rf_c) | (~rf_b & rf_d);   // F
      2'd1:    rf_f = (rf_d & rf_b) | (~rf_d & rf_c);   // G
      2'd2:    rf_f = rf_b ^ rf_c ^ rf_d;               // H
      default: rf_f = rf_c ^ (rf_b | ~rf_d);            // I
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step datapath
  // ---------------------------------------------------------------------------
  logic [3:0]     g_idx;       // message word index for this step
  logic [4:0]     shamt;       // left-rotate amount for this step
  logic [31:0]    msg_word;
  logic [31:0]    tmp_sum;
  logic [31:0]    tmp_rot;
  logic [31:0]    step_b;      // new b produced by this step

  // Message schedule. Only the low four bits of each product matter, so the
  // 6-bit arithmetic (mod 64) truncated to 4 bits gives the required mod 16.
  always_comb begin
    case (rf_sel)
      2'd0:    g_idx = step_q[3:0];
      2'd1:    g_idx = 4'(step_q * 6'd5 + 6'd1);
      2'd2:    g_idx = 4'(step_q * 6'd3 + 6'd5);
      default: g_idx = 4'(step_q * 6'd7);
    endcase
  end

  // Per-round shift amounts, cycling on step mod 4.
  always_comb begin
    case ({rf_sel, step_q[1:0]})
      4'b00_00: shamt = 5'd7;
      4'b00_01: shamt = 5'd12;
      4'b00_10: shamt = 5'd17;
      4'b00_11: shamt = 5'd22;
      4'b01_00: shamt = 5'd5;
      4'b01_01: shamt = 5'd9;
      4'b01_10: shamt = 5'd14;
      4'b01_11: shamt = 5'd20;
      4'b10_00: shamt = 5'd4;
      4'b10_01: shamt = 5'd11;
      4'b10_10: shamt = 5'd16;
      4'b10_11: shamt = 5'd23;
      4'b11_00: shamt = 5'd6;
      4'b11_01: shamt = 5'd10;
      4'b11_10: shamt = 5'd15;
      default:  shamt = 5'd21;
    endcase
  end

  assign msg_word = msg_q[{g_idx, 5'd0} +: 32];
  assign tmp_sum  = a_q + rf_f + K_TABLE[step_q] + msg_word;
  // shamt is never zero, so the right shift is always by 1..31.
  assign tmp_rot  = (tmp_sum << shamt) | (tmp_sum >> (6'd32 - {1'b0, shamt}));
  assign step_b   = b_q + tmp_rot;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    msg_d   = msg_q;
    h0_d    = h0_q;
    h_out_d = h_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;                      // done is a single-cycle pulse

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_d   = msg;
          h0_d    = h_in;
          a_d     = h_in[31:0];
          b_d     = h_in[63:32];
          c_d     = h_in[95:64];
          d_d     = h_in[127:96];
          step_d  = 6'd0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d    = d_q;
        d_d    = c_q;
        c_d    = b_q;
        b_d    = step_b;
        step_d = step_q + 6'd1;          // wraps to 0 after step 63
        if (step_q == 6'd63) begin
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        h_out_d = {h0_q[127:96] + d_q,
                   h0_q[95:64]  + c_q,
                   h0_q[63:32]  + b_q,
                   h0_q[31:0]   + a_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every register samples the values
  // that existed before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the latched block and chaining value are ordinary flops, not a
      // RAM, so clearing them on reset is cheap and makes restart state exact.
      state_q <= ST_IDLE;
      step_q  <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      c_q     <= 32'd0;
      d_q     <= 32'd0;
      msg_q   <= '0;
      h0_q    <= '0;
      h_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      msg_q   <= msg_d;
      h0_q    <= h0_d;
      h_out_q <= h_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign h_out = h_out_q;

endmodule

// File: tb/tb_md5_step_engine.sv
// -----------------------------------------------------------------------------
// tb_md5_step_engine
//
// Self-checking bench for md5_step_engine. Stimulus issues blocks and pushes
// the expected digest and done edge into a queue; a monitor on the falling
// edge pops and compares whenever done is seen, and also checks done width,
// busy span and that h_out holds between done pulses. Random blocks are
// checked against a plain-arithmetic MD5 compression model whose K table is
// derived from the sine definition.
// -----------------------------------------------------------------------------
module tb_md5_step_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] msg;
  logic [127:0] h_in;
  logic         busy;
  logic         done;
  logic [127:0] h_out;

  md5_step_engine dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .msg   (msg),
    .h_in  (h_in),
    .busy  (busy),
    .done  (done),
    .h_out (h_out)
  );

  always #5 clk = ~clk;

  // Rising-edge counter: after edge n (read #1 later or at the next negedge)
  // cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] h;
    int           done_edge;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] EXP_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] EXP_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
  localparam int           SH [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                                         '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  logic [31:0]  k_tab [64];
  logic [511:0] blk_empty;
  logic [511:0] blk_abc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference MD5 compression of one block.
  function automatic logic [127:0] md5_ref(input logic [511:0] m, input logic [127:0] h);
    logic [31:0] mw [16];
    logic [31:0] a, b, c, d, f, t;
    int          g, s;
    for (int j = 0; j < 16; j++) mw[j] = m[32*j +: 32];
    a = h[31:0];
    b = h[63:32];
    c = h[95:64];
    d = h[127:96];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      s = SH[i / 16][i % 4];
      t = a + f + k_tab[i] + mw[g];
      t = (t << s) | (t >> (32 - s));
      a = d;
      d = c;
      c = b;
      b = b + t;
    end
    return {h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] m;
    for (int j = 0; j < 16; j++) m[32*j +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [127:0] rand_hash();
    logic [127:0] h;
    for (int j = 0; j < 4; j++) h[32*j +: 32] = $urandom;
    return h;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [127:0] hold_val  = '0;
  int           busy_cnt  = 0;
  logic         done_prev = 1'b0;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (reset) begin
      busy_cnt  = 0;
      hold_val  = '0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        check("done_width", done_prev, 1'b0);
        check("busy_in_done_cycle", busy, 1'b0);
        check("busy_span", busy_cnt, 65);
        busy_cnt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at edge %0d, expected no pending block", cyc);
          hold_val = h_out;
        end else begin
          mon_e = exp_q.pop_front();
          check("digest", h_out, mon_e.h);
          check("done_edge", cyc, mon_e.done_edge);
          hold_val = mon_e.h;
        end
      end else begin
        check("h_out_hold", h_out, hold_val);
      end
      done_prev = done;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  // Issue one block while the engine is idle; returns #1 after the accept edge
  // with start released and the inputs scrambled.
  task automatic start_block(input logic [511:0] m, input logic [127:0] h,
                             input logic [127:0] expv);
    exp_t e;
    msg   = m;
    h_in  = h;
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    e.h         = expv;
    e.done_edge = cyc + 65;
    exp_q.push_back(e);
    msg  = rand_block();
    h_in = rand_hash();
  endtask

  // Single-cycle start pulse with junk data while the engine is running.
  task automatic junk_start();
    start = 1'b1;
    msg   = rand_block();
    h_in  = rand_hash();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   e0;
    int   n;
    exp_t e;
    real  v;

    for (int i = 0; i < 64; i++) begin
      v = $sin(real'(i + 1));
      if (v < 0.0) v = -v;
      k_tab[i] = 32'(longint'($floor(v * 4294967296.0)));
    end

    blk_empty            = '0;
    blk_empty[31:0]      = 32'h00000080;
    blk_abc              = '0;
    blk_abc[31:0]        = 32'h80636261;
    blk_abc[14*32 +: 32] = 32'h00000018;

    reset = 1'b1;
    start = 1'b0;
    msg   = '0;
    h_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_h_out", h_out, '0);
    reset = 1'b0;

    // Known-answer blocks
    wait_idle();
    start_block(blk_empty, IV, EXP_EMPTY);
    wait_idle();
    start_block(blk_abc, IV, EXP_ABC);

    // Start pulses while busy are ignored
    wait_idle();
    start_block(blk_abc, IV, EXP_ABC);
    repeat (9) @(posedge clk);
    #1;
    junk_start();
    repeat (29) @(posedge clk);
    #1;
    junk_start();

    // Reset part-way through a block, then a clean run
    wait_idle();
    start_block(blk_abc, IV, EXP_ABC);
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_h_out", h_out, '0);
    reset = 1'b0;
    wait_idle();
    start_block(blk_abc, IV, EXP_ABC);

    // Back-to-back: start held high, second block accepted in the done cycle
    wait_idle();
    msg   = blk_empty;
    h_in  = IV;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0          = cyc;
    e.h         = EXP_EMPTY;
    e.done_edge = e0 + 65;
    exp_q.push_back(e);
    e.h         = EXP_ABC;
    e.done_edge = e0 + 65 + 1 + 65;
    exp_q.push_back(e);
    msg = blk_abc;
    repeat (66) @(posedge clk);
    #1;
    check("b2b_second_accept_busy", busy, 1'b1);
    start = 1'b0;
    msg   = rand_block();
    h_in  = rand_hash();

    // Random blocks against the reference model
    for (int r = 0; r < 12; r++) begin
      logic [511:0] m;
      logic [127:0] h;
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      m = rand_block();
      h = rand_hash();
      start_block(m, h, md5_ref(m, h));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #1;
        junk_start();
      end
    end

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d blocks still pending, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
